// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, state encoding and round helper functions.
package sha256_pkg;
  localparam int WORD = 32;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, FINAL} state_t;
  localparam logic [WORD-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [WORD-1:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  function automatic logic [WORD-1:0] rotr32(input logic [WORD-1:0] x, input int n);
    return (x >> n) | (x << (WORD - n));
  endfunction
  function automatic logic [WORD-1:0] sig0(input logic [WORD-1:0] x);
    return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
  endfunction
  function automatic logic [WORD-1:0] sig1(input logic [WORD-1:0] x);
    return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
  endfunction
  function automatic logic [WORD-1:0] ch(input logic [WORD-1:0] e, f, g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [WORD-1:0] maj(input logic [WORD-1:0] a, b, c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
endpackage

// File: rtl/sha256_compress_if.sv
// sha256_compress_if: controller/schedule-side bus of the compression core.
interface sha256_compress_if;
  import sha256_pkg::*;
  logic Start;
  logic [8*WORD-1:0] HashIn;
  logic [WORD-1:0] WIn;
  logic [5:0] Round;
  logic Busy;
  logic Done;
  logic [8*WORD-1:0] HashOut;
  modport master (output Start, HashIn, WIn, input Round, Busy, Done, HashOut);
  modport slave (input Start, HashIn, WIn, output Round, Busy, Done, HashOut);
endinterface

// File: rtl/sha256_round_step.sv
// sha256_round_step: one combinational SHA-256 round over packed a..h (a in the top word).
module sha256_round_step
  import sha256_pkg::*;
(
  input  logic [8*WORD-1:0] cur,
  input  logic [WORD-1:0]   kc,
  input  logic [WORD-1:0]   w,
  output logic [8*WORD-1:0] nxt
);
  logic [WORD-1:0] a, b, c, d, e, f, g, h, t1, t2;
  assign {a, b, c, d, e, f, g, h} = cur;
  assign t1 = h + sig1(e) + ch(e, f, g) + kc + w;
  assign t2 = sig0(a) + maj(a, b, c);
  assign nxt = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: 64-round SHA-256 compression FSM fed one schedule word per cycle.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input logic Clk,
  input logic Rst,
  sha256_compress_if.slave bus
);
  state_t state;
  logic [5:0] k;
  logic [8*WORD-1:0] h_lat, v, nxt;
  sha256_round_step step (.cur(v), .kc(K[k]), .w(bus.WIn), .nxt(nxt));
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      k <= '0;
      h_lat <= '0;
      v <= '0;
      bus.Round <= '0;
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
      bus.HashOut <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.Done <= 1'b0;
          bus.Round <= '0;
          if (bus.Start) begin
            h_lat <= bus.HashIn;
            v <= bus.HashIn;
            bus.Busy <= 1'b1;
            state <= PRIME;
          end
        end
        PRIME: begin
          bus.Round <= 6'd1;
          k <= '0;
          state <= RUN;
        end
        RUN: begin
          v <= nxt;
          k <= k + 6'd1;
          // Round runs one ahead of k because calc_w needs an edge to register W.
          bus.Round <= (k == 6'(ROUNDS - 1)) ? 6'd0 : (k > 6'd60) ? 6'd63 : k + 6'd2;
          if (k == 6'(ROUNDS - 1)) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++)
            bus.HashOut[WORD*i +: WORD] <= h_lat[WORD*i +: WORD] + v[WORD*i +: WORD];
          bus.Done <= 1'b1;
          bus.Round <= '0;
          bus.Busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: directed and random checks of the compression core against a plain SHA-256 model.
module tb_sha256_compress;
  import sha256_pkg::*;
  logic Clk = 1'b0;
  logic Rst;
  int checks = 0;
  int failures = 0;
  logic [31:0] w_tab [64];
  sha256_compress_if bus ();
  sha256_compress #(.ROUNDS(64)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  // calc_w stand-in: registers W[Round] with one edge of latency.
  always @(posedge Clk) bus.WIn <= w_tab[bus.Round];

  localparam logic [255:0] IV_W = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                                 32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                                 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
  localparam logic [511:0] B2 = {448'h0, 64'h1c0};
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ssig(input logic [31:0] x, input int p, input int q, input int r);
    return ror(x, p) ^ ror(x, q) ^ (x >> r);
  endfunction
  task automatic fill(input logic [511:0] blk);
    for (int t = 0; t < 64; t++)
      w_tab[t] = (t < 16) ? blk[511-32*t -: 32]
               : ssig(w_tab[t-2], 17, 19, 10) + w_tab[t-7] + ssig(w_tab[t-15], 7, 18, 3) + w_tab[t-16];
  endtask
  function automatic logic [255:0] ref_hash(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0] w [64];
    logic [31:0] s [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int t = 0; t < 64; t++)
      w[t] = (t < 16) ? blk[511-32*t -: 32]
           : ssig(w[t-2], 17, 19, 10) + w[t-7] + ssig(w[t-15], 7, 18, 3) + w[t-16];
    for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[t] + w[t];
      t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = s[4] + t1;
      s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + s[i];
    return res;
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[32*i +: 32] = $urandom();
    return x;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Called at a negedge; returns at the negedge where Done should be high.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] hin, input bit poke, input string tag);
    logic [255:0] exp;
    exp = ref_hash(blk, hin);
    fill(blk);
    bus.HashIn = hin;
    bus.Start = 1'b1;
    cyc();
    bus.HashIn = rnd256();
    for (int j = 0; j <= 66; j++) begin
      if (j > 0) cyc();
      bus.Start = 1'b0;
      chk($sformatf("%s round j=%0d", tag, j), bus.Round,
          (j == 0 || j > 64) ? 0 : (j > 63 ? 63 : j));
      chk($sformatf("%s busy j=%0d", tag, j), bus.Busy, j < 66);
      chk($sformatf("%s done j=%0d", tag, j), bus.Done, j == 66);
      if (poke && (j == 11 || j == 41)) begin
        bus.Start = 1'b1;
        bus.HashIn = rnd256();
      end
    end
    chk({tag, " hash"}, bus.HashOut, exp);
  endtask

  initial begin
    logic [511:0] blk;
    logic [255:0] hin;
    Rst = 1'b1;
    bus.Start = 1'b0;
    bus.HashIn = '0;
    for (int t = 0; t < 64; t++) w_tab[t] = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset round", bus.Round, 0);
    chk("reset busy", bus.Busy, 0);
    chk("reset done", bus.Done, 0);
    chk("reset hash", bus.HashOut, 0);
    Rst = 1'b0;
    cyc();
    run_block(ABC, IV_W, 1'b0, "abc");
    chk("abc digest", bus.HashOut, ABC_D);
    cyc();
    run_block(EMPTY, IV_W, 1'b0, "empty");
    chk("empty digest", bus.HashOut, EMPTY_D);
    cyc();
    run_block(ABC, IV_W, 1'b1, "abc_poke");
    chk("abc_poke digest", bus.HashOut, ABC_D);
    cyc();
    chk("poke no second done", bus.Done, 0);
    chk("poke idle busy", bus.Busy, 0);
    fill(ABC);
    bus.HashIn = IV_W;
    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
    repeat (31) cyc();
    chk("abort pre round", bus.Round, 31);
    chk("abort pre busy", bus.Busy, 1);
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    chk("abort round", bus.Round, 0);
    chk("abort busy", bus.Busy, 0);
    chk("abort done", bus.Done, 0);
    chk("abort hash", bus.HashOut, 0);
    cyc();
    chk("abort stays idle", bus.Busy, 0);
    run_block(ABC, IV_W, 1'b0, "abc_restart");
    chk("abc_restart digest", bus.HashOut, ABC_D);
    cyc();
    Rst = 1'b1;
    bus.Start = 1'b1;
    cyc();
    Rst = 1'b0;
    bus.Start = 1'b0;
    chk("rst+start busy", bus.Busy, 0);
    cyc();
    chk("rst+start still idle", bus.Busy, 0);
    chk("rst+start round", bus.Round, 0);
    run_block(B1, IV_W, 1'b0, "two_b1");
    run_block(B2, ref_hash(B1, IV_W), 1'b0, "two_b2");
    chk("two-block digest", bus.HashOut, TWO_D);
    for (int n = 0; n < 3; n++) begin
      cyc();
      blk = {rnd256(), rnd256()};
      hin = rnd256();
      run_block(blk, hin, 1'b0, $sformatf("rand%0d", n));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
- SHA-256 compression core; sits directly downstream of the message-schedule stage (calc_w).
- Drives calc_w's Round index and consumes one schedule word per cycle on WIn.
- Runs 64 rounds over working registers a..h, then adds the chaining value to produce the updated 256-bit hash.
- A top-level controller supplies HashIn (IV or previous digest) and Start.

Parameters:
ROUNDS, 64, number of rounds executed (1..64); values below 64 are for reduced-round debug only; production is 64.

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  synchronous active-high reset
Start  input  1  one-cycle request; sampled only in IDLE
HashIn  input  256  chaining value, H0 in [255:224] ... H7 in [31:0]
WIn  input  32  schedule word from calc_w (its WOut)
Round  output  6  round index driven to calc_w
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse; HashOut valid from this cycle on
HashOut  output  256  updated hash, same packing as HashIn; held until next Done or Rst

Behaviour:
- Interface: one clock, Clk. Reset Rst is synchronous and active-high.
- Reset values: Round=0, Busy=0, Done=0, HashOut=0, a..h=0, H latch=0, k=0, state IDLE.
- Rst wins over Start when both are high on the same edge.
- Rst mid-operation aborts the run and returns all outputs to their reset values on that edge.
- States: IDLE, PRIME, RUN, FINAL.
- IDLE:
  - Round=0, Done cleared after its single cycle.
  - Start=1: latch HashIn into H0..H7 and a..h, Round<=0, go to PRIME.
  - Start is accepted in the cycle Done is high.
- PRIME: one cycle. calc_w registers W[0] on the exit edge. Round<=1, k<=0, go to RUN.
- RUN, round k (0..ROUNDS-1):
  - WIn equals W[k] (calc_w has one edge of latency).
  - T1 = h + S1(e) + Ch(e,f,g) + K[k] + WIn.
  - T2 = S0(a) + Maj(a,b,c).
  - Update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - All adds are mod 2^32; carries are discarded.
  - S1 = ROTR6^ROTR11^ROTR25. S0 = ROTR2^ROTR13^ROTR22. Ch = (e&f)^(~e&g). Maj = (a&b)^(a&c)^(b&c).
  - Round<=min(k+2,63), saturating at 63 with no wrap to 0.
  - k<=k+1. At k=ROUNDS-1 go to FINAL.
- FINAL: HashOut_i <= H_i + {a..h}_i mod 2^32; Done<=1; Round<=0; go to IDLE.
- Latency (ROUNDS=64): Start sampled at edge E0; Done high in the cycle after edge E66.
- Throughput: one block per 67 cycles with back-to-back Starts.
- Start while Busy: ignored, with no effect on state or outputs.
- HashIn and WIn are don't-care outside the latch edge and RUN respectively.
- The schedule window (Flat_W_Arr shifting) is not owned by this block. The upstream window logic advances on the same Round value.

Decomposition:
- Package sha256_pkg:
  - K[0:63] round-constant table and IV[0:7] constants.
  - State enum {IDLE, PRIME, RUN, FINAL}.
  - rotr32 function and S0/S1/Ch/Maj functions.
  - Word width constant 32.
- One sub-module sha256_round_step: combinational; inputs a..h, K, W; outputs next a..h. Instantiated once. FSM, counter and final add stay in sha256_compress.

Test Plan:
- "abc" single block: bench calc_w model gives W0=0x61626380, W1..W14=0, W15=0x00000018; HashIn=IV; Start -> Done exactly 66 edges later; HashOut = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: W0=0x80000000, rest 0; HashIn=IV -> HashOut = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Round sequence: check Round=0 in IDLE and PRIME, then 1,2,...,63,63 through RUN, then 0 in FINAL. Busy is high for exactly 66 cycles and Done is high for exactly 1.
- Start pulsed at RUN k=10 and k=40 -> ignored; "abc" digest unchanged; no second Done.
- Rst asserted at RUN k=30 -> next cycle all outputs 0 and state IDLE. Restart "abc" -> correct digest. Rst and Start on the same edge -> stays IDLE.
- Back-to-back: Start in the Done cycle with HashIn = previous digest and a second padded block ("abcdbcdecdef...nopq" two-block vector) -> final HashOut = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
